// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand path: default width, the operand-pair
// type handed from the operand FIFO to the engine, and the FIFO control op encoding.
`timescale 1ns/1ps

package gcd_pkg;

    localparam int GCD_DATA_WIDTH = 8;

    // Operand pair at the default datapath width; field order matches {a, b} packing.
    typedef struct packed {
        logic [GCD_DATA_WIDTH-1:0] a;
        logic [GCD_DATA_WIDTH-1:0] b;
    } gcd_pair_t;

    // Per-edge FIFO operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_t;

endpackage

// File: rtl/gcd_fifo_ctrl.sv
// Pointer, occupancy and flag control for the operand FIFO; carries no data.
// Flush wins over push and pop; full/empty come from the count, not pointer equality.
`timescale 1ns/1ps

module gcd_fifo_ctrl
    import gcd_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push_req,
    input  logic                 pop_req,
    output logic                 wr_en,
    output logic [PTR_WIDTH-1:0] wr_ptr,
    output logic [PTR_WIDTH-1:0] rd_ptr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    logic                 push;
    logic                 pop;
    fifo_op_t             op;
    logic [CNT_WIDTH-1:0] count_nxt;

    assign full  = (count == CNT_WIDTH'(DEPTH));
    assign empty = (count == '0);

    // Handshakes qualify only on registered flags, so no ready depends on the far side.
    assign push  = push_req && !full;
    assign pop   = pop_req && !empty;
    assign op    = fifo_op_t'({push, pop});
    assign wr_en = push && !flush;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_nxt = count;
        case (op)
            OP_PUSH: count_nxt = count + 1'b1;
            OP_POP:  count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural overflow gives the modulo wrap.
            if (push) wr_ptr <= PTR_WIDTH'(wr_ptr + 1'b1);
            if (pop)  rd_ptr <= PTR_WIDTH'(rd_ptr + 1'b1);
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/gcd_operand_fifo.sv
// DEPTH-entry FIFO of (A,B) operand pairs feeding the GCD engine's operand-load stage.
// Build option GCD_OPERAND_ORDER_EN stores each pair ordered so that A >= B.
`timescale 1ns/1ps

module gcd_operand_fifo
    import gcd_pkg::*;
#(
    parameter int DATA_WIDTH = GCD_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_a,
    input  logic [DATA_WIDTH-1:0] s_b,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_a,
    output logic [DATA_WIDTH-1:0] m_b,
    output logic [CNT_WIDTH-1:0]  o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    // Same layout as gcd_pair_t, widened to this instance's DATA_WIDTH.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } pair_t;

    logic                 wr_en;
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    pair_t                in_pair;
    pair_t                mem [DEPTH];

    gcd_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ctrl (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_flush),
        .push_req (s_valid),
        .pop_req  (m_ready),
        .wr_en    (wr_en),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (o_count),
        .full     (o_full),
        .empty    (o_empty)
    );

`ifdef GCD_OPERAND_ORDER_EN
    // Larger operand goes to A so the engine can skip its first compare; ties pass through.
    always_comb begin
        in_pair.a = s_a;
        in_pair.b = s_b;
        if (s_a < s_b) begin
            in_pair.a = s_b;
            in_pair.b = s_a;
        end
    end
`else
    assign in_pair.a = s_a;
    assign in_pair.b = s_b;
`endif

    // NOTE: storage is reset so m_a/m_b read back zero after reset; flush leaves it untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= in_pair;
        end
    end

    assign s_ready = !o_full;
    assign m_valid = !o_empty;
    assign m_a     = mem[rd_ptr].a;
    assign m_b     = mem[rd_ptr].b;

endmodule
